// File: rtl/vga_ctrl_module.sv
// vga_ctrl_module: 640x480@60Hz VGA timing generator and snake-game pixel colourer.
// Counters publish the scan position; sync and RGB are registered one clock behind it.
module vga_ctrl_module #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CELL_SHIFT = 4
) (
  input  logic       Clk_25mhz,
  input  logic       Rst_n,
  input  logic [1:0] Object,
  input  logic [5:0] Apple_x,
  input  logic [4:0] Apple_y,
  input  logic       Apple_type,
  output logic [9:0] Pixel_x,
  output logic [9:0] Pixel_y,
  output logic       Hsync_sig,
  output logic       Vsync_sig,
  output logic       play_VGA_red,
  output logic       play_VGA_green,
  output logic       play_VGA_blue
);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [5:0] COLS   = 6'(H_VISIBLE >> CELL_SHIFT);
  localparam logic [4:0] ROWS   = 5'(V_VISIBLE >> CELL_SHIFT);

  logic [9:0] r_h_cnt, r_v_cnt;
  logic       r_hsync, r_vsync;
  logic [2:0] r_rgb;
  logic       w_visible, w_apple_hit;
  logic [5:0] w_cell_x;
  logic [4:0] w_cell_y;
  logic [2:0] w_rgb;

  assign w_visible   = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign w_cell_x    = 6'(r_h_cnt >> CELL_SHIFT);
  assign w_cell_y    = 5'(r_v_cnt >> CELL_SHIFT);
  // Out-of-grid apple coordinates must never alias onto a visible cell
  assign w_apple_hit = w_visible && (Apple_x < COLS) && (Apple_y < ROWS) &&
                       (w_cell_x == Apple_x) && (w_cell_y == Apple_y);

  always_comb begin
    w_rgb = !w_visible       ? 3'b000 :
            Object == 2'b11  ? 3'b111 :
            Object == 2'b01  ? 3'b110 :
            Object == 2'b10  ? 3'b011 :
            w_apple_hit      ? (Apple_type ? 3'b010 : 3'b100) :
                               3'b000;
  end

  always_ff @(posedge Clk_25mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= 3'b000;
    end else begin
      r_h_cnt <= (r_h_cnt == H_LAST) ? 10'd0 : r_h_cnt + 10'd1;
      if (r_h_cnt == H_LAST)
        r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
      r_hsync <= !((r_h_cnt >= H_SS) && (r_h_cnt < H_SE));
      r_vsync <= !((r_v_cnt >= V_SS) && (r_v_cnt < V_SE));
      r_rgb   <= w_rgb;
    end
  end

  assign Pixel_x        = r_h_cnt;
  assign Pixel_y        = r_v_cnt;
  assign Hsync_sig      = r_hsync;
  assign Vsync_sig      = r_vsync;
  assign play_VGA_red   = r_rgb[2];
  assign play_VGA_green = r_rgb[1];
  assign play_VGA_blue  = r_rgb[0];
endmodule

// File: tb/tb_vga_ctrl_module.sv
// tb_vga_ctrl_module: scoreboard bench for the VGA controller; vertical timing is shortened
// (48 visible lines, 55 total) so a full frame fits in a short run.
module tb_vga_ctrl_module;
  logic       Clk_25mhz = 1'b0;
  logic       Rst_n = 1'b0;
  logic [1:0] Object = 2'b00;
  logic [5:0] Apple_x = 6'd0;
  logic [4:0] Apple_y = 5'd0;
  logic       Apple_type = 1'b0;
  logic [9:0] Pixel_x, Pixel_y;
  logic       Hsync_sig, Vsync_sig, play_VGA_red, play_VGA_green, play_VGA_blue;

  vga_ctrl_module #(.V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut (
    .Clk_25mhz(Clk_25mhz), .Rst_n(Rst_n), .Object(Object), .Apple_x(Apple_x),
    .Apple_y(Apple_y), .Apple_type(Apple_type), .Pixel_x(Pixel_x), .Pixel_y(Pixel_y),
    .Hsync_sig(Hsync_sig), .Vsync_sig(Vsync_sig), .play_VGA_red(play_VGA_red),
    .play_VGA_green(play_VGA_green), .play_VGA_blue(play_VGA_blue)
  );

  always #20 Clk_25mhz = ~Clk_25mhz;

  // Bench-owned clock count since reset release: at cycle N the scan sits at pixel N.
  int cyc = 0;
  always @(posedge Clk_25mhz or negedge Rst_n)
    if (!Rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  typedef struct {
    string nm;
    int    due;
    int    kind;
    int    exp;
  } item_t;
  item_t q[$];
  int checks = 0, errors = 0;

  localparam int K_PX = 0, K_PY = 1, K_HS = 2, K_VS = 3, K_RGB = 4;

  task automatic expect_at(input string nm, input int due, input int kind, input int exp);
    item_t it;
    it.nm = nm; it.due = due; it.kind = kind; it.exp = exp;
    q.push_back(it);
  endtask

  task automatic at_pix(input int n);
    while (cyc < n) @(negedge Clk_25mhz);
  endtask

  function automatic int actual(input int kind);
    case (kind)
      K_PX:    return int'(Pixel_x);
      K_PY:    return int'(Pixel_y);
      K_HS:    return int'(Hsync_sig);
      K_VS:    return int'(Vsync_sig);
      default: return int'({play_VGA_red, play_VGA_green, play_VGA_blue});
    endcase
  endfunction

  initial forever begin
    @(negedge Clk_25mhz or negedge Rst_n);
    #1;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        checks++;
        if (actual(q[i].kind) != q[i].exp) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d (cycle %0d)", q[i].nm, actual(q[i].kind), q[i].exp, cyc);
        end
        q.delete(i);
      end else if (q[i].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: never sampled (due cycle %0d, now %0d)", q[i].nm, q[i].due, cyc);
        q.delete(i);
      end
    end
  end

  initial begin
    expect_at("reset_px", 0, K_PX, 0);
    expect_at("reset_py", 0, K_PY, 0);
    expect_at("reset_hs", 0, K_HS, 1);
    expect_at("reset_vs", 0, K_VS, 1);
    expect_at("reset_rgb", 0, K_RGB, 0);
    #50 Rst_n = 1'b1;
    expect_at("count_1", 1, K_PX, 1);
    expect_at("count_2", 2, K_PX, 2);
    expect_at("count_3", 3, K_PX, 3);
    at_pix(100); Object = 2'b01; expect_at("head", 101, K_RGB, 3'b110);
    at_pix(101); Object = 2'b10; expect_at("body", 102, K_RGB, 3'b011);
    at_pix(102); Object = 2'b11; expect_at("wall", 103, K_RGB, 3'b111);
    at_pix(103); Object = 2'b00; expect_at("none", 104, K_RGB, 3'b000);
    at_pix(650);
    expect_at("hs_before", 656, K_HS, 1);
    expect_at("hs_fall", 657, K_HS, 0);
    expect_at("hs_last", 752, K_HS, 0);
    expect_at("hs_rise", 753, K_HS, 1);
    expect_at("px_799", 799, K_PX, 799);
    expect_at("py_line0", 799, K_PY, 0);
    expect_at("px_wrap", 800, K_PX, 0);
    expect_at("py_line1", 800, K_PY, 1);
    at_pix(700); Object = 2'b11; expect_at("hblank", 701, K_RGB, 3'b000);
    at_pix(701); Object = 2'b00;
    at_pix(12000); Apple_x = 6'd10; Apple_y = 5'd1; Apple_type = 1'b0;
    expect_at("apple_above", 12161, K_RGB, 3'b000);
    expect_at("apple_left", 12960, K_RGB, 3'b000);
    expect_at("apple_tl", 12961, K_RGB, 3'b100);
    expect_at("apple_tr", 12976, K_RGB, 3'b100);
    expect_at("apple_right", 12977, K_RGB, 3'b000);
    expect_at("apple_bl", 24961, K_RGB, 3'b100);
    expect_at("apple_below", 25761, K_RGB, 3'b000);
    at_pix(16165); Object = 2'b11; expect_at("wall_over_apple", 16166, K_RGB, 3'b111);
    at_pix(16166); Object = 2'b00; expect_at("apple_mid", 16167, K_RGB, 3'b100);
    at_pix(26000); Apple_x = 6'd20; Apple_y = 5'd2; Apple_type = 1'b1;
    expect_at("green_left", 32320, K_RGB, 3'b000);
    expect_at("green", 32321, K_RGB, 3'b010);
    at_pix(33000); Apple_x = 6'd45;
    expect_at("apple_x45", 34321, K_RGB, 3'b000);
    expect_at("apple_x45_row", 33921, K_RGB, 3'b000);
    at_pix(38500); Object = 2'b11; expect_at("vblank", 38501, K_RGB, 3'b000);
    at_pix(38501); Object = 2'b00;
    at_pix(39000);
    expect_at("vs_before", 40000, K_VS, 1);
    expect_at("vs_fall", 40001, K_VS, 0);
    expect_at("vs_last", 41600, K_VS, 0);
    expect_at("vs_rise", 41601, K_VS, 1);
    expect_at("frame_last_py", 43999, K_PY, 54);
    expect_at("frame_wrap_py", 44000, K_PY, 0);
    expect_at("frame_wrap_px", 44000, K_PX, 0);
    at_pix(45899); Object = 2'b11;
    expect_at("pre_reset_rgb", 45900, K_RGB, 3'b111);
    expect_at("pre_reset_px", 45900, K_PX, 300);
    expect_at("pre_reset_py", 45900, K_PY, 2);
    at_pix(45900);
    #5;
    expect_at("async_px", 0, K_PX, 0);
    expect_at("async_py", 0, K_PY, 0);
    expect_at("async_hs", 0, K_HS, 1);
    expect_at("async_vs", 0, K_VS, 1);
    expect_at("async_rgb", 0, K_RGB, 0);
    Rst_n = 1'b0;
    @(negedge Clk_25mhz);
    #5 Rst_n = 1'b1;
    Object = 2'b00;
    expect_at("restart_1", 1, K_PX, 1);
    expect_at("restart_py", 1, K_PY, 0);
    expect_at("restart_3", 3, K_PX, 3);
    at_pix(4);
    repeat (2) @(negedge Clk_25mhz);
    #2;
    foreach (q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: never sampled (due cycle %0d)", q[i].nm, q[i].due);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
